// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the 4-bit CPU fetch path.
// Holds the pc/instruction widths, the sequencer FSM state encoding and
// convenience types used by pc_sequencer and pc_next_4b.
package pc_sequencer_pkg;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 8;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pc_next_4b.sv
// Combinational next-pc selector for the fetch sequencer.
// Ports: pc_i/target_i (current pc, jump destination), jmp_i/jz_i/zero_i
// (branch controls), pc_next_o (selected next pc), wrap_o (increment carry-out).
module pc_next_4b
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] target_i,
  input  logic            jmp_i,
  input  logic            jz_i,
  input  logic            zero_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic            wrap_o
);

  logic          take_jump;
  logic [PC_W:0] inc;

  assign take_jump = jmp_i | (jz_i & zero_i);
  assign inc       = {1'b0, pc_i} + (PC_W + 1)'(1);

  assign pc_next_o = take_jump ? target_i : inc[PC_W-1:0];
  // Carry only counts when the increment path is the one taken, so a jump
  // from 15 to 0 never reports a wrap.
  assign wrap_o    = ~take_jump & inc[PC_W];

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: drives the instruction-store select
// bus, captures the returned word in FETCH and strobes it valid in EXEC.
// Ports: clk_i/rst_i, run_i/step_i/halt_req_i mode controls, jmp_i/jz_i/
// zero_i/target_i branch controls, instr_in_i store data; sel3_o..sel0_o pc,
// instr_o/instr_valid_o to decode, halted_o, wrap_o.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  input  logic               step_i,
  input  logic               halt_req_i,
  input  logic               jmp_i,
  input  logic               jz_i,
  input  logic               zero_i,
  input  logic [PC_W-1:0]    target_i,
  input  logic [INSTR_W-1:0] instr_in_i,
  output logic               sel3_o,
  output logic               sel2_o,
  output logic               sel1_o,
  output logic               sel0_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  output logic               halted_o,
  output logic               wrap_o
);

  state_e state_q, state_d;
  pc_t    pc_q, pc_d;
  instr_t instr_q, instr_d;
  logic   valid_q, valid_d;
  logic   halted_q, halted_d;
  logic   wrap_q, wrap_d;
  logic   step_q;
  logic   step_fire;

  pc_t    pc_nxt;
  logic   pc_wrap;

  pc_next_4b u_pc_next (
    .pc_i      (pc_q),
    .target_i  (target_i),
    .jmp_i     (jmp_i),
    .jz_i      (jz_i),
    .zero_i    (zero_i),
    .pc_next_o (pc_nxt),
    .wrap_o    (pc_wrap)
  );

  // A held step only counts on its rising edge, so it triggers once per
  // IDLE visit; an edge seen outside IDLE is simply dropped.
  assign step_fire = step_i & ~step_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (run_i || step_fire) state_d = S_FETCH;
      end
      S_FETCH: begin
        instr_d = instr_in_i;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (halt_req_i) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_nxt;
          wrap_d  = pc_wrap;
          state_d = run_i ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are registered off the next state so they line up
    // exactly with the EXEC/HALT cycles.
    valid_d  = (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      wrap_q   <= wrap_d;
      step_q   <= step_i;
    end
  end

  // Select lines come straight off the pc flops to keep the store path short.
  assign sel3_o        = pc_q[3];
  assign sel2_o        = pc_q[2];
  assign sel1_o        = pc_q[1];
  assign sel0_o        = pc_q[0];
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = halted_q;
  assign wrap_o        = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  typedef struct {
    logic [3:0] pc;
    logic [7:0] instr;
    logic       wrap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i, run_i, step_i, halt_req_i, jmp_i, jz_i, zero_i;
  logic [3:0] target_i;
  logic [7:0] instr_in_i;
  logic       sel3_o, sel2_o, sel1_o, sel0_o;
  logic [7:0] instr_o;
  logic       instr_valid_o, halted_o, wrap_o;

  logic [7:0] rom [16];
  logic [3:0] sel;

  exp_t       sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] m_pc;
  logic       wrap_exp = 1'b0;

  always #5 clk = ~clk;

  assign sel        = {sel3_o, sel2_o, sel1_o, sel0_o};
  assign instr_in_i = rom[sel];

  pc_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .run_i         (run_i),
    .step_i        (step_i),
    .halt_req_i    (halt_req_i),
    .jmp_i         (jmp_i),
    .jz_i          (jz_i),
    .zero_i        (zero_i),
    .target_i      (target_i),
    .instr_in_i    (instr_in_i),
    .sel3_o        (sel3_o),
    .sel2_o        (sel2_o),
    .sel1_o        (sel1_o),
    .sel0_o        (sel0_o),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .halted_o      (halted_o),
    .wrap_o        (wrap_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one executed instruction. Expected fetch is the current
  // model pc and the store word at that address; next pc follows the
  // priority halt > jmp > (jz && zero) > pc+1 mod 16.
  task automatic do_instr(input logic j, input logic jz, input logic zr,
                          input logic [3:0] t, input logic h);
    exp_t e;
    int   nxt;
    e.pc    = m_pc;
    e.instr = rom[m_pc];
    e.wrap  = 1'b0;
    nxt     = int'(m_pc);
    if (!h) begin
      if (j || (jz && zr)) nxt = int'(t);
      else begin
        nxt    = (int'(m_pc) + 1) % 16;
        e.wrap = (m_pc == 4'd15);
      end
    end
    sb.push_back(e);
    jmp_i = j; jz_i = jz; zero_i = zr; target_i = t; halt_req_i = h;
    @(posedge clk); #1;
    @(posedge clk); #1;
    jmp_i = 0; jz_i = 0; zero_i = 0; target_i = 0; halt_req_i = 0;
    m_pc = 4'(nxt);
  endtask

  // Single step from IDLE with step held for 'hold' cycles, then a gap.
  task automatic do_step(input int hold);
    exp_t e;
    e.pc    = m_pc;
    e.instr = rom[m_pc];
    e.wrap  = (m_pc == 4'd15);
    sb.push_back(e);
    step_i = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    step_i = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    m_pc = 4'((int'(m_pc) + 1) % 16);
  endtask

  // Monitor: wrap checked every cycle; each valid strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) wrap_exp = 1'b0;
    chk("wrap", wrap_o, wrap_exp);
    wrap_exp = 1'b0;
    if (instr_valid_o) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got valid at pc %0h, expected none", sel);
      end else begin
        e = sb.pop_front();
        chk("exec_pc", sel, e.pc);
        chk("exec_instr", instr_o, e.instr);
        wrap_exp = e.wrap;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1; run_i = 0; step_i = 0; halt_req_i = 0;
    jmp_i = 0; jz_i = 0; zero_i = 0; target_i = 0;
    for (int i = 0; i < 16; i++) rom[i] = 8'hA0 | 8'(i);
    m_pc = 0;
    #12;
    chk("rst_sel", sel, 4'h0);
    chk("rst_instr", instr_o, 8'h00);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_wrap", wrap_o, 1'b0);

    // Free run from reset across the 15 -> 0 boundary.
    @(posedge clk); #1;
    rst_i = 0; run_i = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 18; i++) do_instr(0, 0, 0, 4'h0, 0);

    // Reset in the middle of a FETCH cycle.
    #2;
    rst_i = 1;
    #1;
    chk("midfetch_instr", instr_o, 8'h00);
    chk("midfetch_valid", instr_valid_o, 1'b0);
    chk("midfetch_sel", sel, 4'h0);
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    @(posedge clk); #1;
    rst_i = 0;
    m_pc = 0;
    @(posedge clk); #1;

    // Randomized branch traffic.
    for (int i = 0; i < 80; i++)
      do_instr(($urandom % 6) == 0, ($urandom % 3) == 0, 1'($urandom),
               4'($urandom), 1'b0);

    // Jump boundaries and conditional branch at pc 5.
    do_instr(1, 0, 0, 4'hF, 0);
    do_instr(1, 0, 0, 4'h0, 0);
    do_instr(1, 0, 0, 4'h0, 0);
    do_instr(1, 0, 0, 4'h5, 0);
    do_instr(0, 1, 0, 4'h9, 0);
    do_instr(1, 0, 0, 4'h5, 0);
    do_instr(0, 1, 1, 4'hC, 0);
    chk("jz_taken_sel", sel, 4'hC);
    do_instr(1, 0, 0, 4'h5, 0);
    do_instr(1, 0, 0, 4'h3, 1);

    // HALT ignores run/step/jmp; only reset leaves.
    for (int i = 0; i < 6; i++) begin
      run_i = 1'($urandom); step_i = 1'($urandom); jmp_i = 1'($urandom);
      target_i = 4'($urandom);
      @(negedge clk);
      chk("halt_flag", halted_o, 1'b1);
      chk("halt_sel", sel, 4'h5);
      chk("halt_instr", instr_o, rom[5]);
      @(posedge clk); #1;
    end
    run_i = 0; step_i = 0; jmp_i = 0; target_i = 0;
    #2;
    rst_i = 1;
    #1;
    chk("halt_rst_sel", sel, 4'h0);
    chk("halt_rst_halted", halted_o, 1'b0);
    @(posedge clk); #1;
    rst_i = 0;
    m_pc = 0;
    @(posedge clk); #1;

    // Step mode: three short pulses, then one held for four cycles.
    do_step(1);
    do_step(1);
    do_step(1);
    do_step(4);
    chk("step_idle_sel", sel, 4'h4);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
